// File: rtl/wb_pkg.sv
// Write-back controller shared types and default widths.
// Optional feature macro: WB_FWD_EN (operand forwarding from the load queue).
package wb_pkg;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DEPTH  = 4;

  // One queued load result; live clears when a younger ALU write hits the same register.
  typedef struct packed {
    logic                 live;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Bus bundle for the write-back controller: ALU/LSU sources, regfile write port, status.
// Optional feature macro: WB_FWD_EN adds the two forwarding read ports.
interface regfile_wb_ctrl_if import wb_pkg::*; #(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_waddr;
  logic [DATA_W-1:0] alu_wdata;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_waddr;
  logic [DATA_W-1:0] lsu_wdata;
  logic              write;
  logic [ADDR_W-1:0] waddr1;
  logic [DATA_W-1:0] din;
  logic [CNT_W-1:0]  wb_pending;
  logic              wb_busy;
`ifdef WB_FWD_EN
  logic [ADDR_W-1:0] fwd_raddr1;
  logic [ADDR_W-1:0] fwd_raddr2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;

  modport master (
    output alu_valid, alu_waddr, alu_wdata, lsu_valid, lsu_waddr, lsu_wdata,
    output fwd_raddr1, fwd_raddr2,
    input  lsu_ready, write, waddr1, din, wb_pending, wb_busy,
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
  modport slave (
    input  alu_valid, alu_waddr, alu_wdata, lsu_valid, lsu_waddr, lsu_wdata,
    input  fwd_raddr1, fwd_raddr2,
    output lsu_ready, write, waddr1, din, wb_pending, wb_busy,
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
`else
  modport master (
    output alu_valid, alu_waddr, alu_wdata, lsu_valid, lsu_waddr, lsu_wdata,
    input  lsu_ready, write, waddr1, din, wb_pending, wb_busy
  );
  modport slave (
    input  alu_valid, alu_waddr, alu_wdata, lsu_valid, lsu_waddr, lsu_wdata,
    output lsu_ready, write, waddr1, din, wb_pending, wb_busy
  );
`endif
endinterface

// File: rtl/wb_fifo.sv
// Circular load-result queue with per-entry kill on address match.
// Optional feature macro: WB_FWD_EN exposes the storage and read pointer for forwarding.
// The caller only pushes when not full and only pops when not empty.
module wb_fifo import wb_pkg::*; #(
  parameter  int DEPTH = WB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [WB_ADDR_W-1:0] i_push_addr,
  input  logic [WB_DATA_W-1:0] i_push_data,
  input  logic                 i_pop,
  input  logic                 i_kill_en,
  input  logic [WB_ADDR_W-1:0] i_kill_addr,
  output wb_entry_t            o_head,
  output logic [CNT_W-1:0]     o_count
`ifdef WB_FWD_EN
  ,
  output wb_entry_t [DEPTH-1:0] o_ents,
  output logic [PTR_W-1:0]      o_rd_ptr
`endif
);
  wb_entry_t [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]      r_rd;
  logic [PTR_W-1:0]      r_wr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_push_live;

  // A push to the same register as the concurrent ALU write is already stale.
  assign w_push_live = !(i_kill_en && (i_push_addr == i_kill_addr));

  // Storage, pointers and occupancy; the push slot is written after the kill sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_kill_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_mem[i].addr == i_kill_addr) r_mem[i].live <= 1'b0;
        end
      end
      if (i_push) begin
        r_mem[r_wr] <= '{live: w_push_live, addr: i_push_addr, data: i_push_data};
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (i_pop) r_rd <= r_rd + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;
`ifdef WB_FWD_EN
  assign o_ents   = r_mem;
  assign o_rd_ptr = r_rd;
`endif
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Regfile write-port controller: ALU results win the slot, queued loads fill idle slots,
// stale loads are squashed by younger ALU writes to the same register.
// Optional feature macro: WB_FWD_EN adds combinational forwarding from queue and output stage.
// DATA_W/ADDR_W must match the wb_pkg entry widths.
module regfile_wb_ctrl import wb_pkg::*; #(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  regfile_wb_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              r_rdy_en;
  logic              r_write;
  logic [ADDR_W-1:0] r_waddr1;
  logic [DATA_W-1:0] r_din;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_cnt;
  wb_entry_t         w_head;
`ifdef WB_FWD_EN
  wb_entry_t [DEPTH-1:0] w_ents;
  logic [PTR_W-1:0]      w_rd_ptr;
`endif

  // Holds lsu_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rdy_en <= 1'b0;
    else      r_rdy_en <= 1'b1;
  end

  assign bus.lsu_ready  = r_rdy_en && (w_cnt != CNT_W'(DEPTH));
  assign w_push         = bus.lsu_valid && bus.lsu_ready;
  assign w_pop          = !bus.alu_valid && (w_cnt != '0);
  assign bus.wb_pending = w_cnt;
  assign bus.wb_busy    = (w_cnt != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_addr(bus.lsu_waddr),
    .i_push_data(bus.lsu_wdata),
    .i_pop      (w_pop),
    .i_kill_en  (bus.alu_valid),
    .i_kill_addr(bus.alu_waddr),
    .o_head     (w_head),
    .o_count    (w_cnt)
`ifdef WB_FWD_EN
    ,
    .o_ents     (w_ents),
    .o_rd_ptr   (w_rd_ptr)
`endif
  );

  // Write-slot arbitration into the registered regfile port; killed heads drain silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write  <= 1'b0;
      r_waddr1 <= '0;
      r_din    <= '0;
    end else if (bus.alu_valid) begin
      r_write  <= 1'b1;
      r_waddr1 <= bus.alu_waddr;
      r_din    <= bus.alu_wdata;
    end else if (w_pop && w_head.live) begin
      r_write  <= 1'b1;
      r_waddr1 <= w_head.addr;
      r_din    <= w_head.data;
    end else begin
      r_write  <= 1'b0;
      r_waddr1 <= '0;
      r_din    <= '0;
    end
  end

  assign bus.write  = r_write;
  assign bus.waddr1 = r_waddr1;
  assign bus.din    = r_din;

`ifdef WB_FWD_EN
  // Output stage is oldest, then queue entries oldest to youngest; the last match wins.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] ra);
    logic              hit;
    logic [DATA_W-1:0] d;
    logic [PTR_W-1:0]  idx;
    hit = 1'b0;
    d   = '0;
    if (r_write && (r_waddr1 == ra)) begin
      hit = 1'b1;
      d   = r_din;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = w_rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < w_cnt) && w_ents[idx].live && (w_ents[idx].addr == ra)) begin
        hit = 1'b1;
        d   = w_ents[idx].data;
      end
    end
    return {hit, d};
  endfunction

  // Combinational forwarding for both decode read ports.
  always_comb begin
    {bus.fwd_hit1, bus.fwd_data1} = fwd_lookup(bus.fwd_raddr1);
    {bus.fwd_hit2, bus.fwd_data2} = fwd_lookup(bus.fwd_raddr2);
  end
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: queue-based reference, per-cycle scoreboard.
// Optional feature macro: WB_FWD_EN enables the forwarding checks.
module tb_regfile_wb_ctrl;
  import wb_pkg::*;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) bus ();
  regfile_wb_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst_n), .bus(bus)
  );

  typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

  int        n_chk = 0;
  int        n_fail = 0;
  wr_t       sb[$];
  wb_entry_t mq[$];
  wr_t       last_out = '{1'b0, '0, '0};
  logic [DW-1:0] rf [32];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

`ifdef WB_FWD_EN
  task automatic fwd_exp(input logic [AW-1:0] ra, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0; d = '0;
    if (last_out.w && last_out.a == ra) begin hit = 1'b1; d = last_out.d; end
    foreach (mq[i]) if (mq[i].live && mq[i].addr == ra) begin hit = 1'b1; d = mq[i].data; end
  endtask
`endif

  // One clock: drive inputs, check status, predict the write, compare after the edge.
  task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    wr_t e;
    wb_entry_t h;
    logic rdy;
    bus.alu_valid = av; bus.alu_waddr = aa; bus.alu_wdata = ad;
    bus.lsu_valid = lv; bus.lsu_waddr = la; bus.lsu_wdata = ld;
    #1;
    rdy = (mq.size() != DEPTH);
    chk("lsu_ready", 64'(bus.lsu_ready), 64'(rdy));
    chk("wb_pending", 64'(bus.wb_pending), 64'(mq.size()));
    chk("wb_busy", 64'(bus.wb_busy), 64'(mq.size() != 0));
`ifdef WB_FWD_EN
    begin
      logic hh; logic [DW-1:0] dd;
      fwd_exp(bus.fwd_raddr1, hh, dd);
      chk("fwd_hit1", 64'(bus.fwd_hit1), 64'(hh));
      chk("fwd_data1", 64'(bus.fwd_data1), 64'(dd));
      fwd_exp(bus.fwd_raddr2, hh, dd);
      chk("fwd_hit2", 64'(bus.fwd_hit2), 64'(hh));
      chk("fwd_data2", 64'(bus.fwd_data2), 64'(dd));
    end
`endif
    if (av) e = '{1'b1, aa, ad};
    else if (mq.size() != 0) begin
      h = mq.pop_front();
      e = h.live ? '{1'b1, h.addr, h.data} : '{1'b0, '0, '0};
    end else e = '{1'b0, '0, '0};
    if (av) foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 1'b0;
    if (lv && rdy) mq.push_back('{live: !(av && la == aa), addr: la, data: ld});
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("write", 64'(bus.write), 64'(e.w));
    chk("waddr1", 64'(bus.waddr1), 64'(e.a));
    chk("din", 64'(bus.din), 64'(e.d));
    last_out = e;
    if (bus.write) rf[bus.waddr1] = bus.din;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    bus.alu_valid = 1'b1; bus.alu_waddr = 5'd3; bus.alu_wdata = 32'h1;
    bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd4; bus.lsu_wdata = 32'h2;
`ifdef WB_FWD_EN
    bus.fwd_raddr1 = 5'd9; bus.fwd_raddr2 = 5'd7;
`endif
    #2 rst_n = 1'b0;
    // Reset with both sources asserted: nothing moves.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_write", 64'(bus.write), 64'd0);
      chk("rst_ready", 64'(bus.lsu_ready), 64'd0);
      chk("rst_pending", 64'(bus.wb_pending), 64'd0);
    end
    @(negedge clk);
    bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", 64'(bus.lsu_ready), 64'd1);
    chk("rel_write", 64'(bus.write), 64'd0);
    idle(1);

    // ALU only, then back-to-back ALU writes.
    step(1'b1, 5'd3, 32'h11, 1'b0, '0, '0);
    chk("alu_r3", 64'(rf[3]), 64'h11);
    for (int i = 0; i < 6; i++) step(1'b1, AW'(8 + i), DW'(i * 3 + 1), 1'b0, '0, '0);

    // Loads drain behind ALU pressure.
    step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd5, 32'hA5);
    step(1'b1, 5'd2, 32'hA2, 1'b1, 5'd6, 32'hB6);
    step(1'b1, 5'd3, 32'hA3, 1'b0, '0, '0);
    idle(3);
    chk("ld_r5", 64'(rf[5]), 64'hA5);
    chk("ld_r6", 64'(rf[6]), 64'hB6);

    // Full queue: fifth attempt refused, then drain in order.
    for (int i = 0; i < 5; i++) step(1'b1, 5'd20, DW'(i), 1'b1, AW'(10 + i), DW'(32'h100 + i));
    chk("full_pending", 64'(bus.wb_pending), 64'd4);
    chk("full_ready", 64'(bus.lsu_ready), 64'd0);
    idle(6);
    chk("full_r13", 64'(rf[13]), 64'h103);
    chk("full_r14", 64'(rf[14]), 64'h0);

    // WAW kill of a queued load, then same-cycle push and ALU to one register.
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h77);
    step(1'b1, 5'd7, 32'h99, 1'b0, '0, '0);
    idle(3);
    chk("waw_r7", 64'(rf[7]), 64'h99);
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h40);
    idle(3);
    chk("waw_r4", 64'(rf[4]), 64'h44);

`ifdef WB_FWD_EN
    // Youngest queued value wins; output stage covers the drain cycle.
    bus.fwd_raddr1 = 5'd9; bus.fwd_raddr2 = 5'd2;
    step(1'b1, 5'd1, 32'h0, 1'b1, 5'd9, 32'h1);
    step(1'b1, 5'd2, 32'h0, 1'b1, 5'd9, 32'h2);
    chk("fwd9_hit", 64'(bus.fwd_hit1), 64'd1);
    chk("fwd9_data", 64'(bus.fwd_data1), 64'h2);
    idle(3);
    chk("fwd9_gone_hit", 64'(bus.fwd_hit1), 64'd0);
    chk("fwd9_gone_data", 64'(bus.fwd_data1), 64'd0);
`endif

    // Randomised traffic on a small register range to provoke conflicts.
    for (int i = 0; i < 300; i++) begin
`ifdef WB_FWD_EN
      bus.fwd_raddr1 = AW'($urandom_range(0, 3));
      bus.fwd_raddr2 = AW'($urandom_range(0, 3));
`endif
      step(1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 3)), DW'($urandom),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom));
    end
    idle(6);

    // Reset mid-operation drops queued loads without a write.
    for (int i = 0; i < 3; i++) step(1'b1, 5'd20, DW'(i), 1'b1, AW'(i), DW'(i + 5));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pending", 64'(bus.wb_pending), 64'd0);
    chk("mid_rst_write", 64'(bus.write), 64'd0);
    chk("mid_rst_ready", 64'(bus.lsu_ready), 64'd0);
    mq.delete();
    last_out = '{1'b0, '0, '0};
    bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_write", 64'(bus.write), 64'd0);
    chk("post_rst_ready", 64'(bus.lsu_ready), 64'd1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
